// File: rtl/core_fetcher.sv
// core_fetcher: instruction-fetch responder for the core controller, with a
// one-entry last-PC instruction buffer, request timeout/retry and sticky error.
module core_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int TIMEOUT_CYCLES        = 64,
    parameter int MAX_RETRIES           = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    input  logic                             flush,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic                             fetch_error
);
    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;
    localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010,
        S_RETRY    = 3'b011,
        S_ERROR    = 3'b111
    } fetch_state_e;

    fetch_state_e                     state_q, state_d;
    logic                             valid_q, valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    logic                             err_q, err_d;
    logic [7:0]                       timer_q, timer_d;
    logic [3:0]                       retry_q, retry_d;
    logic                             buf_valid_q, buf_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] buf_tag_q, buf_tag_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data_q, buf_data_d;
    logic                             buf_hit;

    assign buf_hit = buf_valid_q && (buf_tag_q == current_pc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            valid_q     <= 1'b0;
            addr_q      <= '0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            timer_q     <= '0;
            retry_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end

    // Handshake: mem_read_valid and mem_read_address stay fixed until a cycle
    // with mem_read_ready high (data valid that same cycle) or the timer
    // expires; mem_read_ready has no meaning while mem_read_valid is low.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        instr_d     = instr_q;
        err_d       = err_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;

        case (state_q)
            S_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    if (buf_hit) begin
                        instr_d = buf_data_q;
                        state_d = S_FETCHED;
                    end else begin
                        valid_d = 1'b1;
                        addr_d  = current_pc;
                        timer_d = '0;
                        retry_d = '0;
                        state_d = S_FETCHING;
                    end
                end
            end
            S_FETCHING: begin
                if (mem_read_ready) begin
                    instr_d     = mem_read_data;
                    valid_d     = 1'b0;
                    buf_valid_d = 1'b1;
                    buf_tag_d   = addr_q;
                    buf_data_d  = mem_read_data;
                    state_d     = S_FETCHED;
                end else if (timer_q == TIMER_LAST) begin
                    valid_d = 1'b0;
                    retry_d = retry_q + 4'd1;
                    state_d = S_RETRY;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RETRY: begin
                if (retry_q == RETRY_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    valid_d = 1'b1;
                    timer_d = '0;
                    state_d = S_FETCHING;
                end
            end
            S_FETCHED: begin
                if (core_state == CORE_DECODE) state_d = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush landing on the fill edge still leaves the buffer empty.
        if (flush) buf_valid_d = 1'b0;
    end

    assign mem_read_valid   = valid_q;
    assign mem_read_address = addr_q;
    assign fetcher_state    = state_q;
    assign instruction      = instr_q;
    assign fetch_error      = err_q;
endmodule

// File: tb/tb_core_fetcher.sv
// Bench for core_fetcher: table of fetch transactions, randomized fetches
// against a transaction-level buffer/memory model, and hand-written corners.
module tb_core_fetcher;
    localparam int T   = 4;
    localparam int MAX = 2;

    localparam logic [2:0] CS_IDLE   = 3'b000;
    localparam logic [2:0] CS_FETCH  = 3'b001;
    localparam logic [2:0] CS_DECODE = 3'b010;
    localparam logic [2:0] CS_EXEC   = 3'b011;

    localparam logic [2:0] FS_IDLE     = 3'b000;
    localparam logic [2:0] FS_FETCHED  = 3'b010;
    localparam logic [2:0] FS_RETRY    = 3'b011;
    localparam logic [2:0] FS_ERROR    = 3'b111;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  core_state = CS_IDLE;
    logic [7:0]  current_pc = '0;
    logic        flush = 1'b0;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        ready = 1'b0;
    logic [15:0] rdata = '0;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic        fetch_error;

    int passed = 0;
    int total  = 0;

    core_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRIES(MAX)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .core_state(core_state),
        .current_pc(current_pc),
        .flush(flush),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(ready),
        .mem_read_data(rdata),
        .fetcher_state(fetcher_state),
        .instruction(instruction),
        .fetch_error(fetch_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic do_reset();
        core_state = CS_IDLE; flush = 1'b0; ready = 1'b0; rdata = '0; current_pc = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // One fetch transaction. d1/d2: cycles after valid rises before ready, for
    // the first request and the re-request. Returns requests seen, latency in
    // edges from the FETCH edge to FETCHED, and the instruction then shown.
    task automatic do_fetch(input logic [7:0] pc, input logic [15:0] data,
                            input int d1, input int d2, input bit flush_before,
                            input bit flush_fill, input logic [2:0] cs_during,
                            input int hold, output int reqs, output int lat,
                            output logic [15:0] instr_got);
        int att = 0;
        int idx = 0;
        bit prev_v = 1'b0;
        bit done = 1'b0;
        reqs = 0; lat = 0; instr_got = '0;
        if (flush_before) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        current_pc = pc;
        core_state = CS_FETCH;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            core_state = cs_during;
            flush = 1'b0;
            if (fetcher_state == FS_FETCHED) begin
                done = 1'b1;
                instr_got = instruction;
                ready = 1'b0;
                check("fetched_valid_low", 32'(mem_read_valid), 32'd0);
                core_state = (hold > 0) ? CS_FETCH : CS_DECODE;
            end else if (mem_read_valid) begin
                if (!prev_v) reqs++;
                check("req_addr", 32'(mem_read_address), 32'(pc));
                if (idx == ((att == 0) ? d1 : d2)) begin
                    ready = 1'b1; rdata = data;
                    if (flush_fill) flush = 1'b1;
                end else begin
                    ready = 1'b0; rdata = 16'($urandom);
                end
                idx++;
            end else begin
                if (prev_v) begin att++; idx = 0; end
                ready = (fetcher_state == FS_RETRY);
                rdata = ~data;
            end
            prev_v = mem_read_valid;
        end
        ready = 1'b0;
        if (!done) begin
            check("fetch_bound", 32'd0, 32'd1);
            core_state = CS_IDLE;
        end else begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check("hold_state", 32'(fetcher_state), 32'(FS_FETCHED));
                check("hold_instr", 32'(instruction), 32'(instr_got));
                if (k == hold - 1) core_state = CS_DECODE;
            end
            @(posedge clk); #1;
            check("to_idle", 32'(fetcher_state), 32'(FS_IDLE));
            core_state = CS_IDLE;
        end
    endtask

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] data;
        int          d1;
        int          d2;
        bit          fb;
        bit          ff;
        logic [2:0]  cs;
        int          hold;
        int          exp_reqs;
        int          exp_lat;
        logic [15:0] exp_instr;
    } vec_t;

    vec_t        tbl[12];
    logic [15:0] mem_m[256];
    logic [7:0]  hot_pcs[4];
    logic [2:0]  cs_opts[3];

    initial begin
        int reqs, lat, n, nreq;
        bit prev;
        logic [15:0] got;

        // pc, data, d1, d2, flush_before, flush_on_fill, core_state during, hold,
        // expected requests, latency, instruction
        tbl[0]  = '{8'h05, 16'hA1B2, 3, 0, 1'b0, 1'b0, CS_FETCH,  1, 1, 5, 16'hA1B2};
        tbl[1]  = '{8'h05, 16'h0000, 0, 0, 1'b0, 1'b0, CS_FETCH,  2, 0, 1, 16'hA1B2};
        tbl[2]  = '{8'h05, 16'h1234, 1, 0, 1'b1, 1'b0, CS_FETCH,  0, 1, 3, 16'h1234};
        tbl[3]  = '{8'h05, 16'h0000, 0, 0, 1'b0, 1'b0, CS_FETCH,  1, 0, 1, 16'h1234};
        tbl[4]  = '{8'h06, 16'h5555, 0, 0, 1'b0, 1'b0, CS_DECODE, 0, 1, 2, 16'h5555};
        tbl[5]  = '{8'h05, 16'h1234, 0, 0, 1'b0, 1'b0, CS_FETCH,  0, 1, 2, 16'h1234};
        tbl[6]  = '{8'hFF, 16'h00FF, 6, 1, 1'b0, 1'b0, CS_FETCH,  1, 2, 8, 16'h00FF};
        tbl[7]  = '{8'hFF, 16'h0000, 0, 0, 1'b0, 1'b0, CS_FETCH,  0, 0, 1, 16'h00FF};
        tbl[8]  = '{8'h00, 16'hFFFF, 3, 0, 1'b0, 1'b0, CS_EXEC,   1, 1, 5, 16'hFFFF};
        tbl[9]  = '{8'h00, 16'h0000, 0, 0, 1'b0, 1'b0, CS_FETCH,  0, 0, 1, 16'hFFFF};
        tbl[10] = '{8'h40, 16'hBEEF, 2, 0, 1'b0, 1'b1, CS_FETCH,  0, 1, 4, 16'hBEEF};
        tbl[11] = '{8'h40, 16'hBEEF, 0, 0, 1'b0, 1'b0, CS_FETCH,  0, 1, 2, 16'hBEEF};
        hot_pcs = '{8'h05, 8'h10, 8'h11, 8'hFE};
        cs_opts = '{CS_FETCH, CS_EXEC, CS_DECODE};

        // Reset values
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(fetcher_state), 32'(FS_IDLE));
        check("rst_valid", 32'(mem_read_valid), 32'd0);
        check("rst_addr", 32'(mem_read_address), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_err", 32'(fetch_error), 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_fetch(tbl[i].pc, tbl[i].data, tbl[i].d1, tbl[i].d2, tbl[i].fb, tbl[i].ff,
                     tbl[i].cs, tbl[i].hold, reqs, lat, got);
            check($sformatf("tbl%0d_reqs", i), 32'(reqs), 32'(tbl[i].exp_reqs));
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("tbl%0d_instr", i), 32'(got), 32'(tbl[i].exp_instr));
            check($sformatf("tbl%0d_err", i), 32'(fetch_error), 32'd0);
        end

        // Randomized fetches against a one-entry buffer + memory image model
        do_reset();
        begin
            bit          m_v = 1'b0;
            logic [7:0]  m_tag = '0;
            logic [15:0] m_data = '0;
            for (int a = 0; a < 256; a++) mem_m[a] = 16'($urandom);
            for (int i = 0; i < 150; i++) begin
                logic [7:0]  pc;
                bit          fb, ff, hit;
                int          d1, d2, hold, e_reqs, e_lat;
                logic [2:0]  cs;
                logic [15:0] e_instr;
                pc   = ($urandom_range(0, 3) != 0) ? hot_pcs[$urandom_range(0, 3)] : 8'($urandom);
                fb   = ($urandom_range(0, 7) == 0);
                ff   = ($urandom_range(0, 7) == 0);
                d1   = $urandom_range(0, 6);
                d2   = $urandom_range(0, T - 1);
                cs   = cs_opts[$urandom_range(0, 2)];
                hold = $urandom_range(0, 2);
                if (fb) begin
                    m_v = 1'b0;
                    for (int a = 0; a < 256; a++) mem_m[a] = 16'($urandom);
                end
                hit     = m_v && (m_tag == pc);
                e_instr = hit ? m_data : mem_m[pc];
                e_reqs  = hit ? 0 : ((d1 >= T) ? 2 : 1);
                e_lat   = hit ? 1 : ((d1 >= T) ? (T + d2 + 3) : (d1 + 2));
                if (!hit) begin
                    m_v = !ff; m_tag = pc; m_data = mem_m[pc];
                end
                do_fetch(pc, mem_m[pc], d1, d2, fb, ff, cs, hold, reqs, lat, got);
                check("rnd_reqs", 32'(reqs), 32'(e_reqs));
                check("rnd_lat", 32'(lat), 32'(e_lat));
                check("rnd_instr", 32'(got), 32'(e_instr));
                check("rnd_err", 32'(fetch_error), 32'd0);
            end
        end

        // Ready never returned: two timeouts end in the sticky error state
        current_pc = 8'h33; core_state = CS_FETCH; ready = 1'b0;
        n = 0; nreq = 0; prev = 1'b0;
        while (fetcher_state != FS_ERROR && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (mem_read_valid && !prev) nreq++;
            if (n == T + 1) begin
                check("retry_state", 32'(fetcher_state), 32'(FS_RETRY));
                check("retry_valid_low", 32'(mem_read_valid), 32'd0);
                check("retry_err_low", 32'(fetch_error), 32'd0);
            end
            if (n == T + 2) check("rerequest_valid", 32'(mem_read_valid), 32'd1);
            prev = mem_read_valid;
        end
        check("error_latency", 32'(n), 32'(2 * T + 3));
        check("error_reqs", 32'(nreq), 32'd2);
        check("error_flag", 32'(fetch_error), 32'd1);
        for (int k = 0; k < 5; k++) begin
            ready = 1'b1;
            @(posedge clk); #1;
            check("error_state", 32'(fetcher_state), 32'(FS_ERROR));
            check("error_no_req", 32'(mem_read_valid), 32'd0);
            check("error_sticky", 32'(fetch_error), 32'd1);
        end
        ready = 1'b0;

        // Async reset mid-request clears the buffer and drops valid at once
        do_reset();
        do_fetch(8'h77, 16'h7777, 0, 0, 1'b0, 1'b0, CS_FETCH, 0, reqs, lat, got);
        do_fetch(8'h77, 16'h0000, 0, 0, 1'b0, 1'b0, CS_FETCH, 0, reqs, lat, got);
        check("pre_reset_hit", 32'(reqs), 32'd0);
        current_pc = 8'h78; core_state = CS_FETCH;
        @(posedge clk); #1;
        check("mid_valid", 32'(mem_read_valid), 32'd1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_valid", 32'(mem_read_valid), 32'd0);
        check("async_state", 32'(fetcher_state), 32'(FS_IDLE));
        core_state = CS_IDLE;
        @(posedge clk); #2;
        reset_n = 1'b1;
        do_fetch(8'h77, 16'h7777, 0, 0, 1'b0, 1'b0, CS_FETCH, 0, reqs, lat, got);
        check("post_reset_miss", 32'(reqs), 32'd1);
        check("post_reset_lat", 32'(lat), 32'd2);
        check("post_reset_instr", 32'(got), 32'h7777);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
